// File: rtl/add1_pg.sv
// add1_pg: one-bit full-adder cell with carry propagate/generate and optional registered copies
module add1_pg #(
    parameter bit PROP_OR = 1'b0,
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic p,
    output logic g,
    output logic co,
    output logic s_q,
    output logic p_q,
    output logic g_q,
    output logic co_q
);
    always_comb begin
        s  = a ^ b ^ c;
        g  = a & b;
        p  = PROP_OR ? (a | b) : (a ^ b);
        co = g | (p & c);
    end
    generate
        if (REG_OUT) begin : g_reg
            logic s_d, p_d, g_d, co_d;
            always_comb begin
                s_d  = s;
                p_d  = p;
                g_d  = g;
                co_d = co;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_q  <= 1'b0;
                    p_q  <= 1'b0;
                    g_q  <= 1'b0;
                    co_q <= 1'b0;
                end else begin
                    s_q  <= s_d;
                    p_q  <= p_d;
                    g_q  <= g_d;
                    co_q <= co_d;
                end
            end
        end else begin : g_noreg
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign s_q  = 1'b0;
            assign p_q  = 1'b0;
            assign g_q  = 1'b0;
            assign co_q = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_add1_pg.sv
// tb_add1_pg: randomized scoreboard bench over three parameter builds of add1_pg
module tb_add1_pg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0;
    logic [3:0] o0, o1, o2, r0, r1, r2;
    typedef struct packed {logic r; logic a; logic b; logic c;} stim_t;
    stim_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    add1_pg #(.PROP_OR(1'b0), .REG_OUT(1'b1)) u0 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .s(o0[3]), .p(o0[2]), .g(o0[1]), .co(o0[0]),
        .s_q(r0[3]), .p_q(r0[2]), .g_q(r0[1]), .co_q(r0[0]));
    add1_pg #(.PROP_OR(1'b1), .REG_OUT(1'b1)) u1 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .s(o1[3]), .p(o1[2]), .g(o1[1]), .co(o1[0]),
        .s_q(r1[3]), .p_q(r1[2]), .g_q(r1[1]), .co_q(r1[0]));
    add1_pg #(.PROP_OR(1'b0), .REG_OUT(1'b0)) u2 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .s(o2[3]), .p(o2[2]), .g(o2[1]), .co(o2[0]),
        .s_q(r2[3]), .p_q(r2[2]), .g_q(r2[1]), .co_q(r2[0]));

    // Arithmetic view of a full adder: {s,p,g,co}
    function automatic logic [3:0] model(logic ma, logic mb, logic mc, bit por);
        int sum;
        sum = int'(ma) + int'(mb) + int'(mc);
        return {1'(sum % 2), por ? (ma | mb) : (ma ^ mb), ma & mb, sum >= 2};
    endfunction

    task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_comb();
        chk("comb_xor", o0, model(a, b, c, 1'b0));
        chk("comb_or", o1, model(a, b, c, 1'b1));
        chk("comb_noreg", o2, model(a, b, c, 1'b0));
    endtask

    task automatic drive(logic r, logic [2:0] v);
        @(posedge clk);
        #1;
        rst = r;
        {a, b, c} = v;
        q.push_back('{r: r, a: v[2], b: v[1], c: v[0]});
    endtask

    always @(negedge clk) begin
        stim_t e;
        if (mon_on) begin
            chk_comb();
            chk("reg_noreg", r2, 4'b0000);
            if (q.size() > 1) begin
                e = q.pop_front();
                chk("reg_xor", r0, e.r ? 4'b0000 : model(e.a, e.b, e.c, 1'b0));
                chk("reg_or", r1, e.r ? 4'b0000 : model(e.a, e.b, e.c, 1'b1));
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = 3'(i);
            #2;
            chk_comb();
            #3;
        end
        mon_on = 1'b1;
        drive(1'b1, 3'b000);
        drive(1'b1, 3'b000);
        drive(1'b0, 3'b111);
        drive(1'b0, 3'b111);
        drive(1'b1, 3'b111);
        drive(1'b0, 3'b111);
        drive(1'b0, 3'b000);
        #1 a = 1'b1;
        #1 chk("glitch_s", {o0[3], o1[3], o2[3], 1'b0}, 4'b1110);
        a = 1'b0;
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)));
        @(posedge clk);
        @(posedge clk);
        #1 mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
